wait_pass_monitor: RTL and testbench



---
 rtl/wait_pass_monitor.sv | 128 ++++++++++++
 tb/tb_wait_pass_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wait_pass_monitor.sv
// wait_pass_monitor
//   End-of-test detector for simulation. Watches the commit stream of the
//   core, counts elapsed cycles and retired instructions, and counts
//   retirements of the write_tohost instruction (TOHOST_PC). The result
//   checker waits for done (hit count == HIT_TARGET).
//
// Ports
//   clk                    : clock, all state updates on posedge
//   rst                    : synchronous active-high reset
//   commit_valid           : one instruction retires this cycle
//   commit_pc              : PC of the retiring instruction (XLEN bits)
//   pc_write_to_host_cnt   : retirements at TOHOST_PC, saturates at HIT_TARGET
//   pc_write_to_host_cycle : cycle_count captured at the first TOHOST_PC hit
//   valid_ir_cycle         : retired instruction count
//   cycle_count            : cycles since reset release
//   done                   : pc_write_to_host_cnt == HIT_TARGET
//   timeout                : sticky watchdog flag (WAIT_PASS_TIMEOUT_EN only)
//
// Build option
//   `define WAIT_PASS_TIMEOUT_EN adds the timeout port and a watchdog that
//   fires when cycle_count reaches TIMEOUT_CYCLES before done.

module wait_pass_monitor #(
    parameter int unsigned        XLEN           = 64,
    parameter logic [XLEN-1:0]    TOHOST_PC      = 64'h8000_0040,
    parameter int unsigned        HIT_TARGET     = 8,
    parameter logic [31:0]        TIMEOUT_CYCLES = 32'd2_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    output logic [31:0]     pc_write_to_host_cnt,
    output logic [31:0]     pc_write_to_host_cycle,
    output logic [31:0]     valid_ir_cycle,
    output logic [31:0]     cycle_count,
    output logic            done
`ifdef WAIT_PASS_TIMEOUT_EN
    ,
    output logic            timeout
`endif
);

    localparam logic [31:0] TARGET = 32'(HIT_TARGET);

    logic [31:0] hit_cnt_q,  hit_cnt_d;
    logic [31:0] hit_cyc_q,  hit_cyc_d;
    logic [31:0] ir_cnt_q,   ir_cnt_d;
    logic [31:0] cyc_cnt_q,  cyc_cnt_d;
    logic        hit;
    logic        done_w;
    logic        freeze;

    assign hit    = commit_valid && (commit_pc == TOHOST_PC);
    assign done_w = (hit_cnt_q == TARGET);

`ifdef WAIT_PASS_TIMEOUT_EN
    logic timeout_q, timeout_d;

    // Cycle and instruction counters stop on either end condition; the hit
    // counter keeps running after a timeout so the checker still sees hits.
    assign freeze = done_w || timeout_q;
`else
    assign freeze = done_w;
`endif

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        hit_cyc_d = hit_cyc_q;
        ir_cnt_d  = ir_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
`ifdef WAIT_PASS_TIMEOUT_EN
        timeout_d = timeout_q;
`endif

        if (!freeze) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
            if (commit_valid) begin
                ir_cnt_d = ir_cnt_q + 32'd1;
            end
`ifdef WAIT_PASS_TIMEOUT_EN
            // Flag is raised on the same edge cycle_count lands on the limit,
            // so cycle_count holds exactly at TIMEOUT_CYCLES.
            if (cyc_cnt_d == TIMEOUT_CYCLES) begin
                timeout_d = 1'b1;
            end
`endif
        end

        if (hit && (hit_cnt_q < TARGET)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
            // First hit records the pre-increment cycle count.
            if (hit_cnt_q == '0) begin
                hit_cyc_d = cyc_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q <= '0;
            hit_cyc_q <= '0;
            ir_cnt_q  <= '0;
            cyc_cnt_q <= '0;
`ifdef WAIT_PASS_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            hit_cnt_q <= hit_cnt_d;
            hit_cyc_q <= hit_cyc_d;
            ir_cnt_q  <= ir_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
`ifdef WAIT_PASS_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign pc_write_to_host_cnt   = hit_cnt_q;
    assign pc_write_to_host_cycle = hit_cyc_q;
    assign valid_ir_cycle         = ir_cnt_q;
    assign cycle_count            = cyc_cnt_q;
    assign done                   = done_w;
`ifdef WAIT_PASS_TIMEOUT_EN
    assign timeout                = timeout_q;
`endif

endmodule

// File: tb/tb_wait_pass_monitor.sv
// Testbench for wait_pass_monitor: directed steps, expected outputs pushed
// to a queue by a reference model when each step is driven, popped and
// compared after the following posedge.

module tb_wait_pass_monitor;

    localparam logic [63:0] TOHOST = 64'h8000_0040;
    localparam int unsigned TGT    = 8;
    localparam logic [31:0] TOLIM  = 32'd100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit_valid = 1'b0;
    logic [63:0] commit_pc = '0;
    logic [31:0] pc_write_to_host_cnt;
    logic [31:0] pc_write_to_host_cycle;
    logic [31:0] valid_ir_cycle;
    logic [31:0] cycle_count;
    logic        done;
    logic        timeout_obs;

`ifdef WAIT_PASS_TIMEOUT_EN
    logic        timeout;
    assign timeout_obs = timeout;
`else
    assign timeout_obs = 1'b0;
`endif

    wait_pass_monitor #(
        .XLEN           (64),
        .TOHOST_PC      (TOHOST),
        .HIT_TARGET     (TGT),
        .TIMEOUT_CYCLES (TOLIM)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .commit_valid           (commit_valid),
        .commit_pc              (commit_pc),
        .pc_write_to_host_cnt   (pc_write_to_host_cnt),
        .pc_write_to_host_cycle (pc_write_to_host_cycle),
        .valid_ir_cycle         (valid_ir_cycle),
        .cycle_count            (cycle_count),
        .done                   (done)
`ifdef WAIT_PASS_TIMEOUT_EN
        ,
        .timeout                (timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] hcyc;
        logic [31:0] ir;
        logic [31:0] cyc;
        logic        dn;
        logic        to;
    } exp_t;

    exp_t q[$];

    // Reference model state
    logic [31:0] m_cnt = '0, m_hcyc = '0, m_ir = '0, m_cyc = '0;
    logic        m_to = 1'b0;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance the model by one edge with the given inputs.
    task automatic model(input logic v, input logic [63:0] pc, input logic r);
        logic dn_now;
        logic hit;
        if (r) begin
            m_cnt = '0; m_hcyc = '0; m_ir = '0; m_cyc = '0; m_to = 1'b0;
        end else begin
            dn_now = (m_cnt == TGT);
            hit    = v && (pc == TOHOST);
            if (hit && m_cnt < TGT) begin
                if (m_cnt == 0) m_hcyc = m_cyc;
                m_cnt = m_cnt + 1;
            end
            if (!(dn_now || m_to)) begin
                m_cyc = m_cyc + 1;
                if (v) m_ir = m_ir + 1;
`ifdef WAIT_PASS_TIMEOUT_EN
                if (m_cyc == TOLIM) m_to = 1'b1;
`endif
            end
        end
    endtask

    // Drive one cycle, push the expected result, then compare after the edge.
    task automatic step(input logic v, input logic [63:0] pc, input logic r);
        exp_t e;
        rst          = r;
        commit_valid = v;
        commit_pc    = pc;
        model(v, pc, r);
        e.cnt = m_cnt; e.hcyc = m_hcyc; e.ir = m_ir; e.cyc = m_cyc;
        e.dn  = (m_cnt == TGT); e.to = m_to;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("hit_cnt",   pc_write_to_host_cnt,   e.cnt);
            chk("hit_cycle", pc_write_to_host_cycle, e.hcyc);
            chk("ir_cnt",    valid_ir_cycle,         e.ir);
            chk("cycle_cnt", cycle_count,            e.cyc);
            chk("done",      {31'd0, done},          {31'd0, e.dn});
            chk("timeout",   {31'd0, timeout_obs},   {31'd0, e.to});
        end
    endtask

    initial begin
        // Reset held for 5 cycles
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        chk("rst_cycle", cycle_count, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);

        // 10 idle cycles after release
        for (int i = 0; i < 10; i++) step(1'b0, 64'h8000_1234, 1'b0);
        chk("idle_cycle", cycle_count, 32'd10);
        chk("idle_ir",    valid_ir_cycle, 32'd0);
        chk("idle_hits",  pc_write_to_host_cnt, 32'd0);

        // 20 commits at non-tohost PCs
        for (int i = 0; i < 20; i++) step(1'b1, 64'h8000_1000 + 64'(4 * i), 1'b0);
        chk("nonhit_ir",   valid_ir_cycle, 32'd20);
        chk("nonhit_hits", pc_write_to_host_cnt, 32'd0);

        // Tohost PC without commit_valid is ignored; idle up to cycle 37
        for (int i = 0; i < 7; i++) step(1'b0, TOHOST, 1'b0);
        chk("invalid_pc_hits", pc_write_to_host_cnt, 32'd0);
        chk("pre_hit_cycle",   cycle_count, 32'd37);

        // PC differing only in upper bits must not hit
        step(1'b1, TOHOST | 64'h1_0000_0000_0000, 1'b0);
        chk("upper_bits_hits", pc_write_to_host_cnt, 32'd0);
        // Now at cycle 38; the test-plan first hit at 37 is done after a reset below.

        // 12 hits: saturate at 8, counters freeze once done
        for (int i = 0; i < 12; i++) step(1'b1, TOHOST, 1'b0);
        chk("sat_hits",   pc_write_to_host_cnt, 32'd8);
        chk("first_hit",  pc_write_to_host_cycle, 32'd38);
        chk("frz_cycle",  cycle_count, 32'd46);
        chk("frz_ir",     valid_ir_cycle, 32'd29);
        chk("sat_done",   {31'd0, done}, 32'd1);

        // Reset pulse after done, with a hit in the reset cycle
        step(1'b1, TOHOST, 1'b1);
        chk("rst_hits",  pc_write_to_host_cnt, 32'd0);
        chk("rst_done2", {31'd0, done}, 32'd0);

        // Hit on first cycle after release records cycle 0
        step(1'b1, TOHOST, 1'b0);
        chk("first_edge_hit_cycle", pc_write_to_host_cycle, 32'd0);
        chk("first_edge_cycle",     cycle_count, 32'd1);

        // Test-plan scenario: first hit at cycle 37, 7 more consecutive hits
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 37; i++) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, TOHOST, 1'b0);
        chk("plan_hit_cycle", pc_write_to_host_cycle, 32'd37);
        chk("plan_hits",      pc_write_to_host_cnt, 32'd8);
        chk("plan_done",      {31'd0, done}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 64'h8000_2000, 1'b0);
        chk("plan_frz_cycle", cycle_count, 32'd45);
        chk("plan_frz_ir",    valid_ir_cycle, 32'd8);

`ifdef WAIT_PASS_TIMEOUT_EN
        // Watchdog: no hits, cycle_count holds at the limit with timeout high
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 110; i++) step(1'b1, 64'h8000_3000, 1'b0);
        chk("to_flag",  {31'd0, timeout_obs}, 32'd1);
        chk("to_cycle", cycle_count, 32'd100);
        chk("to_ir",    valid_ir_cycle, 32'd100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
